// File: rtl/midi_voice_in_pkg.sv
// mypackage: shared types and constants for the MIDI voice front end.
//   frequency                 - oscillator pitch word for the nco (fixed point)
//   FREQUENCY_FRACTIONAL_BITS - fractional bits of a frequency word
//   midi_note                 - 7-bit MIDI key number
//   MIDI_* constants          - status nibbles and system-message boundaries
//   uart_state_t / parser_state_t - receiver and parser state encodings
//   note_to_freq()            - elaboration-time key -> pitch word conversion
package mypackage;

  localparam int FREQUENCY_WIDTH = 32;
  localparam int FREQUENCY_FRACTIONAL_BITS = 16;
  typedef logic [FREQUENCY_WIDTH-1:0] frequency;

  typedef logic [6:0] midi_note;

  localparam logic [3:0] MIDI_STATUS_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_STATUS_NOTE_ON = 4'h9;
  localparam logic [7:0] MIDI_SYSTEM_COMMON_FIRST = 8'hF0;
  localparam logic [7:0] MIDI_REALTIME_FIRST = 8'hF8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_state_t;

  typedef enum logic [2:0] {
    IDLE,
    ON_KEY,
    ON_VEL,
    OFF_KEY,
    OFF_VEL,
    SKIP
  } parser_state_t;

  // Equal-tempered pitch with A4 (key 69) = 440 Hz, scaled to the fixed-point
  // format and rounded to nearest. Only ever evaluated as a constant, so the
  // real arithmetic never reaches hardware.
  function automatic frequency note_to_freq(input int key);
    real hz;
    real scaled;
    real limit;
    hz = 440.0 * (2.0 ** ((real'(key) - 69.0) / 12.0));
    scaled = hz * (2.0 ** FREQUENCY_FRACTIONAL_BITS);
    limit = (2.0 ** FREQUENCY_WIDTH) - 1.0;
    if (scaled >= limit) begin
      return '1;
    end
    return frequency'(longint'($floor(scaled + 0.5)));
  endfunction

endpackage

// File: rtl/midi_voice_in_if.sv
// midi_voice_in_if: received-byte stream from the serial receiver to the parser.
//   data_byte     - last correctly framed byte
//   byte_valid    - one-cycle strobe, data_byte is new
//   framing_error - one-cycle strobe, stop bit was low and the byte was dropped
// Modports: master (receiver side, drives), slave (parser side, observes).
interface midi_voice_in_if;

  logic [7:0] data_byte;
  logic byte_valid;
  logic framing_error;

  modport master (output data_byte, output byte_valid, output framing_error);
  modport slave (input data_byte, input byte_valid, input framing_error);

endinterface

// File: rtl/midi_voice_in_uart_rx.sv
// midi_uart_rx: 8N1 serial receiver, LSB first, bit period CLK_HZ/BAUD clocks.
// Ports:
//   CLOCK_50 - system clock
//   reset    - asynchronous, active-high
//   rx       - asynchronous serial input, idle high
//   rx_bus   - byte stream out (data_byte, byte_valid, framing_error); the
//              byte output is called data_byte because "byte" is a keyword
module midi_uart_rx
  import mypackage::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 31250
) (
  input logic CLOCK_50,
  input logic reset,
  input logic rx,
  midi_voice_in_if.master rx_bus
);

  localparam int BIT_CLKS = CLK_HZ / BAUD;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CNT_W = $clog2(BIT_CLKS + 1);

  uart_state_t state;
  uart_state_t state_next;
  logic rx_meta;
  logic rx_sync;
  logic [CNT_W-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic half_done;
  logic bit_done;

  assign half_done = (cnt == CNT_W'(HALF_CLKS - 1));
  assign bit_done = (cnt == CNT_W'(BIT_CLKS - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A start edge is only trusted if the line is still low half a bit later;
  // from then on every full bit period lands in the middle of the next bit.
  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE: if (!rx_sync) state_next = RX_START;
      RX_START: if (half_done) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA: if (bit_done && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP: if (bit_done) state_next = RX_IDLE;
      default: state_next = RX_IDLE;
    endcase
  end

  // The synchroniser resets to the idle level so leaving reset never looks
  // like a start bit.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      rx_bus.data_byte <= '0;
      rx_bus.byte_valid <= 1'b0;
      rx_bus.framing_error <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_bus.byte_valid <= 1'b0;
      rx_bus.framing_error <= 1'b0;

      if (state == RX_IDLE || state_next != state || bit_done) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == RX_START) begin
        bit_idx <= '0;
      end

      if (state == RX_DATA && bit_done) begin
        shift <= {rx_sync, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end

      if (state == RX_STOP && bit_done) begin
        if (rx_sync) begin
          rx_bus.data_byte <= shift;
          rx_bus.byte_valid <= 1'b1;
        end else begin
          rx_bus.framing_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/midi_voice_in.sv
// midi_voice_in: MIDI serial input to monophonic voice controls.
// Decodes note-on / note-off on one channel with last-note priority and drives
// the pitch word and gate for an nco/adsr pair.
// Ports:
//   CLOCK_50      - system clock
//   reset         - asynchronous, active-high
//   rx            - asynchronous MIDI serial input, idle high
//   freq          - pitch word for the nco, table[note]
//   gate          - envelope gate for the adsr
//   note          - current key number
//   velocity      - velocity of the current note-on
//   note_valid    - one-cycle pulse per accepted note-on
//   framing_error - one-cycle pulse when a stop bit is low
// Parameters: CLK_HZ, BAUD (bit period CLK_HZ/BAUD clocks), CHANNEL (0..15).
// Build option: MIDI_RUNNING_STATUS_EN - when defined, completed note messages
// leave the parser waiting for another key so running status is honoured;
// otherwise every message must carry its own status byte.
module midi_voice_in
  import mypackage::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 31250,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input logic CLOCK_50,
  input logic reset,
  input logic rx,
  output frequency freq,
  output logic gate,
  output midi_note note,
  output logic [6:0] velocity,
  output logic note_valid,
  output logic framing_error
);

  // The parser state doubles as running status: returning to ON_KEY/OFF_KEY
  // after a message is what lets the next data pair reuse the last status.
`ifdef MIDI_RUNNING_STATUS_EN
  localparam parser_state_t AFTER_ON = ON_KEY;
  localparam parser_state_t AFTER_OFF = OFF_KEY;
`else
  localparam parser_state_t AFTER_ON = IDLE;
  localparam parser_state_t AFTER_OFF = IDLE;
`endif

  midi_voice_in_if rx_bus ();

  midi_uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD)
  ) u_uart_rx (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .rx(rx),
    .rx_bus(rx_bus)
  );

  frequency note_table [128];

  for (genvar k = 0; k < 128; k++) begin : g_note_table
    localparam frequency ENTRY = note_to_freq(k);
    assign note_table[k] = ENTRY;
  end

  parser_state_t state;
  parser_state_t state_next;
  logic [7:0] rx_byte;
  midi_note key_reg;
  logic capture_key;
  logic voice_on;
  logic voice_off;

  assign rx_byte = rx_bus.data_byte;
  assign framing_error = rx_bus.framing_error;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Realtime bytes (0xF8-0xFF) may be interleaved anywhere and must not
  // disturb a message in progress, so they fall through with no effect.
  always_comb begin
    state_next = state;
    capture_key = 1'b0;
    voice_on = 1'b0;
    voice_off = 1'b0;
    if (rx_bus.framing_error) begin
      state_next = IDLE;
    end else if (rx_bus.byte_valid) begin
      if (rx_byte >= MIDI_REALTIME_FIRST) begin
        state_next = state;
      end else if (rx_byte >= MIDI_SYSTEM_COMMON_FIRST) begin
        state_next = IDLE;
      end else if (rx_byte[7]) begin
        if (rx_byte[7:4] == MIDI_STATUS_NOTE_ON && rx_byte[3:0] == CHANNEL) begin
          state_next = ON_KEY;
        end else if (rx_byte[7:4] == MIDI_STATUS_NOTE_OFF && rx_byte[3:0] == CHANNEL) begin
          state_next = OFF_KEY;
        end else begin
          state_next = SKIP;
        end
      end else begin
        case (state)
          ON_KEY: begin
            capture_key = 1'b1;
            state_next = ON_VEL;
          end
          ON_VEL: begin
            if (rx_byte[6:0] != 7'd0) begin
              voice_on = 1'b1;
            end else begin
              voice_off = 1'b1;
            end
            state_next = AFTER_ON;
          end
          OFF_KEY: begin
            capture_key = 1'b1;
            state_next = OFF_VEL;
          end
          OFF_VEL: begin
            voice_off = 1'b1;
            state_next = AFTER_OFF;
          end
          default: state_next = state;
        endcase
      end
    end
  end

  // Last-note priority: a new note-on simply overwrites the voice and keeps
  // the gate high; a note-off only releases the key that is actually sounding.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_reg <= '0;
      freq <= '0;
      gate <= 1'b0;
      note <= '0;
      velocity <= '0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (capture_key) begin
        key_reg <= rx_byte[6:0];
      end
      if (voice_on) begin
        note <= key_reg;
        velocity <= rx_byte[6:0];
        freq <= note_table[key_reg];
        gate <= 1'b1;
        note_valid <= 1'b1;
      end else if (voice_off && key_reg == note && gate) begin
        gate <= 1'b0;
      end
    end
  end

endmodule

// File: doc/midi_voice_in.md
MIDI_VOICE_IN -- requirements
Module: midi_voice_in

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI serial bit rate.
REQ-003 SHALL have parameter CHANNEL, default 0, 4-bit MIDI channel accepted (0..15 = channels 1..16).
REQ-004 SHALL have port CLOCK_50  input  1  system clock; reset is asynchronous, active-high, clocked by CLOCK_50.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port rx  input  1  asynchronous MIDI serial in, idle high.
REQ-007 SHALL have port freq  output  frequency  oscillator pitch word for the nco.
REQ-008 SHALL have port gate  output  1  envelope gate for the adsr.
REQ-009 SHALL have port note  output  7  current MIDI key number.
REQ-010 SHALL have port velocity  output  7  current note-on velocity.
REQ-011 SHALL have port note_valid  output  1  one-cycle pulse on every accepted note-on.
REQ-012 SHALL have port framing_error  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-013 SHALL synchronise rx through two flops before use.
REQ-014 SHALL receive 8N1 frames, LSB first, bit period CLK_HZ/BAUD clocks (1600 at defaults).
REQ-015 SHALL confirm the start bit low at half-period (800 clocks), else return to idle without a byte.
REQ-016 SHALL sample data bits and the stop bit at mid-bit; stop=0 SHALL pulse framing_error, discard the byte, and force parser to IDLE.
REQ-017 SHALL run parser states IDLE, ON_KEY, ON_VEL, OFF_KEY, OFF_VEL, SKIP.
REQ-018 SHALL on status 0x9n (n==CHANNEL) enter ON_KEY; 0x8n (n==CHANNEL) enter OFF_KEY; other 0x80-0xEF enter SKIP.
REQ-019 SHALL ignore bytes 0xF8-0xFF entirely, preserving parser state; SHALL treat 0xF0-0xF7 as entering IDLE and clearing running status.
REQ-020 SHALL discard data bytes (bit7=0) in IDLE and SKIP, except as in REQ-033.
REQ-021 SHALL on note-on with velocity>0 set note, velocity, freq=table[key], gate=1 and pulse note_valid, all on the cycle after the stop-bit sample.
REQ-022 SHALL treat note-on with velocity 0 as note-off.
REQ-023 SHALL on note-off clear gate only if key==note and gate==1; freq, note, and velocity SHALL hold.
REQ-024 SHALL use last-note priority: a note-on while gate=1 replaces note/freq, gate stays 1, no gate gap.
REQ-025 SHALL compute table[k] = round(440*2^((k-69)/12) * 2^FREQUENCY_FRACTIONAL_BITS), saturated to the frequency maximum.

Reset
REQ-026 SHALL on reset drive freq=0, gate=0, note=0, velocity=0, note_valid=0, framing_error=0.
REQ-027 SHALL on reset put receiver in idle, parser in IDLE, and clear running status; a frame in progress SHALL be abandoned.
REQ-028 SHALL resume decoding at the first start bit after reset deasserts.

Configuration
REQ-029 SHALL recognise macro MIDI_RUNNING_STATUS_EN.
REQ-030 SHALL, with MIDI_RUNNING_STATUS_EN defined, return to ON_KEY/OFF_KEY after a completed message so further data-byte pairs reuse the last status.
REQ-031 SHALL, with MIDI_RUNNING_STATUS_EN undefined, return to IDLE after every completed message.
REQ-032 SHALL, with MIDI_RUNNING_STATUS_EN undefined, contain no running-status register.
REQ-033 SHALL, with MIDI_RUNNING_STATUS_EN defined, resume running status after realtime bytes; SKIP with running status SHALL consume data without output.

Structure
REQ-034 SHALL place MIDI status constants, a 7-bit midi_note typedef, and the note-to-frequency table/function in mypackage, reusing frequency and FREQUENCY_FRACTIONAL_BITS.
REQ-035 SHALL instantiate one sub-module midi_uart_rx (outputs byte, byte_valid, framing_error); parser and voice registers SHALL stay in midi_voice_in.

Verification
REQ-036 SHALL cover: 0x90 0x45 0x64 -> note=69, velocity=100, gate=1, freq=440<<FREQUENCY_FRACTIONAL_BITS, one note_valid pulse.
REQ-037 SHALL cover: then 0x80 0x45 0x40 -> gate=0, freq still 440<<FREQUENCY_FRACTIONAL_BITS, note=69.
REQ-038 SHALL cover: on 0x45, on 0x51, off 0x45 -> gate stays 1 throughout, freq=880<<FREQUENCY_FRACTIONAL_BITS, note=81.
REQ-039 SHALL cover: 0x90 0x3C 0x64 0x40 0x64 -> macro defined: note=64, two note_valid pulses; undefined: note=60, one pulse.
REQ-040 SHALL cover: 0x90 0x3C 0xF8 0x64 -> note=60, gate=1; 0x91 0x3C 0x64 (CHANNEL=0) -> no output change.
REQ-041 SHALL cover: stop bit forced low -> framing_error one-cycle pulse, outputs unchanged; reset mid-frame -> all outputs 0, next clean 0x90 0x45 0x64 decoded correctly.
